// File: rtl/gtp_link_pkg.sv
// Shared link-sequencer state encoding and transmit word constants.
package gtp_link_pkg;

  typedef enum logic [1:0] {WAIT, BOND, SYNC, DATA} link_state_t;

  localparam logic [63:0] BOND_W     = 64'h1CFEFBDC_00000000;
  localparam logic [7:0]  BOND_K     = 8'h0F;
  localparam logic [63:0] SYNC_W     = 64'h00000000_FCFCFCFC;
  localparam logic [7:0]  SYNC_K     = 8'hFF;
  localparam logic [15:0] COMMA_BC50 = 16'hBC50;
  localparam logic [7:0]  IDLE_K     = 8'h03;

  function automatic logic [63:0] payload_word(input logic [47:0] data);
    return {data, COMMA_BC50};
  endfunction

endpackage

// File: rtl/gtp_bond_frame_gen.sv
// Bonding frame timer: frame counter plus saturating count of bond words emitted.
module gtp_bond_frame_gen #(
  parameter int unsigned FRAME_BITS = 5,
  parameter int unsigned BOND_COUNT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_enable,
  output logic       o_bond_slot,
  output logic       o_bond_last,
  output logic [7:0] o_bond_cnt
);

  logic [FRAME_BITS-1:0] r_frame_cnt;
  logic [7:0]            r_bond_cnt;

  assign o_bond_slot = &r_frame_cnt;
  assign o_bond_last = o_bond_slot && (r_bond_cnt == 8'(BOND_COUNT - 1));
  assign o_bond_cnt  = r_bond_cnt;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_frame_cnt <= '0;
      r_bond_cnt  <= '0;
    end else if (i_enable) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
      if (o_bond_slot && (r_bond_cnt != 8'hFF))
        r_bond_cnt <= r_bond_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gtp_tx_link_sequencer.sv
// GTP transmit link sequencer: wait for lane reset-done, bond, comma-sync, then payload.
module gtp_tx_link_sequencer
  import gtp_link_pkg::*;
#(
  parameter int unsigned DONE_STABLE = 16,
  parameter int unsigned FRAME_BITS  = 5,
  parameter int unsigned BOND_COUNT  = 255,
  parameter int unsigned SYNC_WORDS  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  gtp_reset_done,
  input  logic        rebond_req,
  input  logic [47:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        prbs_rst,
  output logic [63:0] tx_data,
  output logic [7:0]  tx_iskchar,
  output logic        link_up,
  output logic [7:0]  bond_cnt
);

  link_state_t r_state;
  logic [7:0]  r_stable_cnt;
  logic [3:0]  r_sync_cnt;
  logic [63:0] r_tx_data;
  logic [7:0]  r_tx_k;

  logic w_done_ok;
  logic w_bond_clear;
  logic w_bond_enable;
  logic w_bond_slot;
  logic w_bond_last;

  assign w_done_ok     = &gtp_reset_done;
  // Bond counters restart on any lane loss, while waiting, and on a rebond request.
  assign w_bond_clear  = !w_done_ok || (r_state == WAIT) ||
                         ((r_state == DATA) && rebond_req);
  assign w_bond_enable = (r_state == BOND) && w_done_ok;

  gtp_bond_frame_gen #(
    .FRAME_BITS (FRAME_BITS),
    .BOND_COUNT (BOND_COUNT)
  ) u_frame_gen (
    .clock       (clock),
    .reset       (reset),
    .i_clear     (w_bond_clear),
    .i_enable    (w_bond_enable),
    .o_bond_slot (w_bond_slot),
    .o_bond_last (w_bond_last),
    .o_bond_cnt  (bond_cnt)
  );

  assign src_ready  = (r_state == DATA);
  assign link_up    = (r_state == DATA);
  assign prbs_rst   = (r_state == WAIT) || (r_state == BOND);
  assign tx_data    = r_tx_data;
  assign tx_iskchar = r_tx_k;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= WAIT;
      r_stable_cnt <= '0;
      r_sync_cnt   <= '0;
      r_tx_data    <= '0;
      r_tx_k       <= '0;
    end else if (!w_done_ok) begin
      r_state      <= WAIT;
      r_stable_cnt <= '0;
      r_sync_cnt   <= '0;
      r_tx_data    <= '0;
      r_tx_k       <= '0;
    end else begin
      case (r_state)
        WAIT: begin
          r_tx_data <= '0;
          r_tx_k    <= '0;
          if (r_stable_cnt == 8'(DONE_STABLE - 1)) begin
            r_state      <= BOND;
            r_stable_cnt <= '0;
          end else begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
          end
        end
        BOND: begin
          r_tx_data <= w_bond_slot ? BOND_W : '0;
          r_tx_k    <= w_bond_slot ? BOND_K : '0;
          if (w_bond_last)
            r_state <= SYNC;
        end
        SYNC: begin
          r_tx_data <= SYNC_W;
          r_tx_k    <= SYNC_K;
          if (r_sync_cnt == 4'(SYNC_WORDS - 1)) begin
            r_state    <= DATA;
            r_sync_cnt <= '0;
          end else begin
            r_sync_cnt <= r_sync_cnt + 1'b1;
          end
        end
        DATA: begin
          r_tx_data <= payload_word(src_valid ? src_data : '0);
          r_tx_k    <= IDLE_K;
          if (rebond_req)
            r_state <= BOND;
        end
        default: begin
          r_state   <= WAIT;
          r_tx_data <= '0;
          r_tx_k    <= '0;
        end
      endcase
    end
  end

endmodule
